// File: rtl/autocorr_pkg.sv
// autocorr_pkg
//   Shared types and helpers for the lag-autocorrelation accumulator.
//   - WORD_W_DEF : default word width (matches the upstream serial-to-parallel packer)
//   - AGR_MAX_W  : widest word the agreement() helper accepts
//   - state_t    : output-stream FSM states
//   - acc_width(): accumulator width able to hold WINDOW*WORD_W
//   - agreement(): number of bit positions in which two words agree
package autocorr_pkg;

  localparam int WORD_W_DEF = 3;
  localparam int AGR_MAX_W  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Smallest width that can represent every value 0..window*word_w.
  function automatic int acc_width(input int window, input int word_w);
    return $clog2(window * word_w + 1);
  endfunction

  // Callers zero-extend both words to AGR_MAX_W; the padding XORs to zero,
  // so only the low w bits affect the popcount.
  function automatic logic [7:0] agreement(input logic [AGR_MAX_W-1:0] a,
                                           input logic [AGR_MAX_W-1:0] b,
                                           input int                   w);
    logic [AGR_MAX_W-1:0] x;
    int                   pc;
    x  = a ^ b;
    pc = 0;
    for (int i = 0; i < AGR_MAX_W; i++) begin
      pc += int'(x[i]);
    end
    return 8'(w - pc);
  endfunction

endpackage

// File: rtl/autocorr_lag_cell.sv
// autocorr_lag_cell
//   One lag of the autocorrelation: gates the contribution on history being
//   available, computes the bit agreement between the current word and the
//   lagged word, and accumulates it over the window.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : strobe, cur_word/hist_word are meaningful this cycle
//   terminal   : this strobe is the last of the window; accumulator clears
//   cur_word   : word arriving now
//   hist_word  : word received LAG strobes earlier (cur_word for lag 0)
//   hist_ok    : enough words have been seen since reset for this lag
//   sum        : accumulator plus this cycle's contribution (window result
//                when terminal is high)
module autocorr_lag_cell
  import autocorr_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ACC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              terminal,
  input  logic [WORD_W-1:0] cur_word,
  input  logic [WORD_W-1:0] hist_word,
  input  logic              hist_ok,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] contrib;

  always_comb begin
    contrib = '0;
    if (in_valid && hist_ok) begin
      contrib = ACC_W'(agreement(AGR_MAX_W'(cur_word), AGR_MAX_W'(hist_word), WORD_W));
    end
  end

  assign sum = acc + contrib;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (in_valid) begin
      // The terminal word is already folded into sum, which the top latches.
      if (terminal) acc <= '0;
      else          acc <= sum;
    end
  end

endmodule

// File: rtl/autocorr_lag_accumulator.sv
// autocorr_lag_accumulator
//   Accumulates bit-agreement counts between each incoming word and the words
//   0..NUM_LAGS-1 strobes earlier, over windows of WINDOW words. At the end of
//   a window the per-lag totals are latched and streamed out, lag 0 first.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_word    : packed word from upstream
//   in_valid   : one-cycle strobe for in_word (never back-pressured)
//   res_data   : agreement count for lag res_lag
//   res_lag    : lag index of the current beat
//   res_valid  : beat valid
//   res_last   : beat carries lag NUM_LAGS-1
//   res_ready  : downstream accepts the beat
//   overrun    : one-cycle pulse, a window's results were dropped
//   dbg_state  : output FSM state
// Handshake: a beat transfers on a rising clk edge where res_valid and
//   res_ready are both high. While res_valid is high and res_ready low,
//   res_data/res_lag/res_last hold. res_valid never drops without a transfer.
module autocorr_lag_accumulator
  import autocorr_pkg::*;
#(
  parameter  int WORD_W   = WORD_W_DEF,
  parameter  int NUM_LAGS = 4,
  parameter  int WINDOW   = 64,
  localparam int ACC_W    = acc_width(WINDOW, WORD_W),
  localparam int LAG_W    = $clog2(NUM_LAGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic [LAG_W-1:0]  res_lag,
  output logic              res_valid,
  output logic              res_last,
  input  logic              res_ready,
  output logic              overrun,
  output state_t            dbg_state
);

  localparam int               CNT_W    = $clog2(WINDOW);
  localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(NUM_LAGS - 1);

  // hist[k] is the word received k strobes ago.
  logic [WORD_W-1:0] hist     [1:NUM_LAGS-1];
  logic [LAG_W-1:0]  prior_cnt;   // words seen since reset, saturating
  logic [CNT_W-1:0]  win_cnt;
  logic              terminal;

  logic [WORD_W-1:0] lag_word [NUM_LAGS];
  logic              lag_ok   [NUM_LAGS];
  logic [ACC_W-1:0]  lag_sum  [NUM_LAGS];
  logic [ACC_W-1:0]  res_buf  [NUM_LAGS];

  state_t            state;
  logic              fire;
  logic [LAG_W-1:0]  next_lag;

  assign terminal  = in_valid && (win_cnt == CNT_W'(WINDOW - 1));
  assign fire      = res_valid && res_ready;
  assign next_lag  = res_lag + 1'b1;
  assign dbg_state = state;

  always_comb begin
    lag_word[0] = in_word;
    lag_ok[0]   = 1'b1;
    for (int k = 1; k < NUM_LAGS; k++) begin
      lag_word[k] = hist[k];
      lag_ok[k]   = (prior_cnt >= LAG_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_LAGS; g++) begin : g_lag
    autocorr_lag_cell #(
      .WORD_W (WORD_W),
      .ACC_W  (ACC_W)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .terminal  (terminal),
      .cur_word  (in_word),
      .hist_word (lag_word[g]),
      .hist_ok   (lag_ok[g]),
      .sum       (lag_sum[g])
    );
  end

  // History and window counting run regardless of the output side.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < NUM_LAGS; k++) hist[k] <= '0;
      prior_cnt <= '0;
      win_cnt   <= '0;
    end else if (in_valid) begin
      hist[1] <= in_word;
      for (int k = 2; k < NUM_LAGS; k++) hist[k] <= hist[k-1];
      if (prior_cnt != LAST_LAG) prior_cnt <= prior_cnt + 1'b1;
      if (terminal) win_cnt <= '0;
      else          win_cnt <= win_cnt + 1'b1;
    end
  end

  // Output FSM. A terminal strobe wins over the end-of-stream transition so a
  // window ending on the last-beat handshake reloads without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_lag   <= '0;
      res_data  <= '0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_LAGS; k++) res_buf[k] <= '0;
    end else begin
      overrun <= 1'b0;

      if (fire) begin
        if (res_last) begin
          state     <= IDLE;
          res_valid <= 1'b0;
          res_last  <= 1'b0;
          res_lag   <= '0;
          res_data  <= '0;
        end else begin
          res_lag  <= next_lag;
          res_data <= res_buf[next_lag];
          res_last <= (next_lag == LAST_LAG);
        end
      end

      if (terminal) begin
        if (state == IDLE || (fire && res_last)) begin
          for (int k = 0; k < NUM_LAGS; k++) res_buf[k] <= lag_sum[k];
          state     <= STREAM;
          res_valid <= 1'b1;
          res_last  <= 1'b0;
          res_lag   <= '0;
          res_data  <= lag_sum[0];
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
